// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_WIDTH = 8;
  // sclk edges in one transfer: one leading and one trailing edge per bit
  localparam int SPI_EDGES = 2 * SPI_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // mode[1] = CPOL, mode[0] = CPHA
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response signals plus the serial pins of one SPI master.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while the master is idle; busy reports occupancy.
interface spi_master_if;
  import spi_pkg::*;

  logic                 start;
  logic [1:0]           mode;
  logic [SPI_WIDTH-1:0] tx_data;
  logic                 miso;
  logic                 sclk;
  logic                 mosi;
  logic                 ss;
  logic [SPI_WIDTH-1:0] rx_data;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, mode, tx_data, miso,
    output sclk, mosi, ss, rx_data, busy, done
  );

  modport slave (
    output start, mode, tx_data, miso,
    input  sclk, mosi, ss, rx_data, busy, done
  );

endinterface

// File: rtl/spi_clkgen.sv
// sclk generator: half-period counter, edge counter and sclk toggle with lead/trail strobes.
// Latency: strobes are combinational and mark the inclk edge on which sclk toggles.
// Backpressure: none; runs freely while run=1, restarted by clear.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic inclk,
  input  logic reset,
  input  logic clear,      // start of a transfer: restart counters, park sclk at cpol
  input  logic run,        // transfer in progress
  input  logic cpol,
  output logic sclk,
  output logic tick,       // a half period has elapsed on this edge
  output logic lead,       // this edge toggles sclk away from its idle level
  output logic trail,      // this edge returns sclk to its idle level
  output logic last_edge   // this edge is the final trailing edge of the transfer
);

  localparam logic [7:0] HP_LAST    = 8'(CLK_DIV - 1);
  localparam logic [4:0] EDGE_TOTAL = 5'(SPI_EDGES);

  logic [7:0] hp_cnt;
  logic [4:0] edge_cnt;
  logic       edge_due;

  assign tick      = run && (hp_cnt == HP_LAST);
  // after the last edge tick keeps running (it times HOLD) but sclk stays put
  assign edge_due  = tick && (edge_cnt != EDGE_TOTAL);
  assign lead      = edge_due && !edge_cnt[0];
  assign trail     = edge_due && edge_cnt[0];
  assign last_edge = trail && (edge_cnt == EDGE_TOTAL - 5'd1);

  // half-period timing, edge counting and the sclk flop itself
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      hp_cnt   <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (clear) begin
      hp_cnt   <= '0;
      edge_cnt <= '0;
      sclk     <= cpol;
    end else if (run) begin
      hp_cnt <= tick ? 8'd0 : hp_cnt + 8'd1;
      if (edge_due) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: one byte per transfer, all four CPOL/CPHA modes, MSB first.
// Latency: done 17*CLK_DIV inclk cycles after ss falls (start accepted on the ss-fall edge).
// Backpressure: start ignored while busy; start in the done cycle begins the next transfer.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic          inclk,
  input logic          reset,
  spi_master_if.master bus
);

  spi_state_t           state;
  logic [SPI_WIDTH-1:0] shreg;
  logic [SPI_WIDTH-1:0] rx_q;
  logic                 cpha_q;
  logic                 mosi_q;
  logic                 ss_q;
  logic                 busy_q;
  logic                 done_q;

  logic accept;
  logic running;
  logic sclk_w;
  logic tick;
  logic lead;
  logic trail;
  logic last_edge;

  assign accept  = (state == IDLE) && bus.start;
  assign running = (state != IDLE);

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .inclk     (inclk),
    .reset     (reset),
    .clear     (accept),
    .run       (running),
    .cpol      (bus.mode[1]),
    .sclk      (sclk_w),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge)
  );

  // transfer sequencing, shift register and all registered outputs
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      rx_q   <= '0;
      cpha_q <= 1'b0;
      mosi_q <= 1'b0;
      ss_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SETUP;
            cpha_q <= bus.mode[0];
            shreg  <= bus.tx_data;
            ss_q   <= 1'b0;
            busy_q <= 1'b1;
            // CPHA=0 peripherals sample on the first edge, so bit 7 must already be out
            if (!bus.mode[0]) mosi_q <= bus.tx_data[SPI_WIDTH-1];
          end
        end
        SETUP: if (lead) state <= XFER;
        XFER:  if (last_edge) state <= HOLD;
        HOLD: begin
          if (tick) begin
            state  <= IDLE;
            ss_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            rx_q   <= shreg;
          end
        end
        default: state <= IDLE;
      endcase

      // received bits enter at the LSB as transmitted bits leave from the MSB
      if (lead) begin
        if (!cpha_q) shreg  <= {shreg[SPI_WIDTH-2:0], bus.miso};
        else         mosi_q <= shreg[SPI_WIDTH-1];
      end
      if (trail) begin
        if (cpha_q)          shreg  <= {shreg[SPI_WIDTH-2:0], bus.miso};
        else if (!last_edge) mosi_q <= shreg[SPI_WIDTH-1];
      end
    end
  end

  assign bus.sclk    = sclk_w;
  assign bus.mosi    = mosi_q;
  assign bus.ss      = ss_q;
  assign bus.rx_data = rx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: a peripheral model per DUT plus a scoreboard checked on done.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master;
  import spi_pkg::*;

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       cpol;
  } exp_t;

  logic inclk = 1'b0;
  logic reset = 1'b1;

  // stimulus-owned per-DUT controls (index 0: CLK_DIV=4, index 1: CLK_DIV=1)
  logic       start_s   [2];
  logic [1:0] mode_s    [2];
  logic [7:0] tx_s      [2];
  logic       slv_loop  [2];
  logic [1:0] slv_mode  [2];
  logic [7:0] slv_resp  [2];
  bit         back2back [2];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  spi_master_if bus[2] ();

  always #5 inclk = ~inclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int DIV = (g == 0) ? 4 : 1;

    logic       miso_m   = 1'b0;
    int         cyc      = 0;
    int         fall_cyc = 0;
    int         done_cyc = 0;
    int         edges    = 0;
    int         viol     = 0;
    int         out_idx  = 0;
    logic [7:0] cap      = 8'h00;
    logic       p_ss     = 1'b1;
    logic       p_sclk   = 1'b0;
    logic       p_mosi   = 1'b0;
    bit         have_done = 1'b0;

    spi_master #(.CLK_DIV(DIV)) u_dut (
      .inclk (inclk),
      .reset (reset),
      .bus   (bus[g])
    );

    assign bus[g].start   = start_s[g];
    assign bus[g].mode    = mode_s[g];
    assign bus[g].tx_data = tx_s[g];
    assign bus[g].miso    = slv_loop[g] ? bus[g].mosi : miso_m;

    // peripheral model and scoreboard monitor, sampled away from the active edge
    always @(negedge inclk) begin
      exp_t e;
      bit   lead;
      bit   samp;
      cyc++;
      if (reset) begin
        have_done = 1'b0;
      end else begin
        if (p_ss && !bus[g].ss) begin
          if (back2back[g] && have_done) chk("ss_high_gap", cyc - done_cyc, 1);
          fall_cyc = cyc;
          edges    = 0;
          viol     = 0;
          cap      = 8'h00;
          out_idx  = 7;
          if (!slv_mode[g][0]) begin
            miso_m  = slv_resp[g][7];
            out_idx = 6;
          end
        end else if (!p_ss && !bus[g].ss) begin
          if (bus[g].sclk != p_sclk) begin
            edges++;
            lead = (bus[g].sclk != slv_mode[g][1]);
            samp = lead ^ slv_mode[g][0];
            if (samp) begin
              cap = {cap[6:0], bus[g].mosi};
              if (bus[g].mosi != p_mosi) viol++;
            end else if (out_idx >= 0) begin
              miso_m  = slv_resp[g][out_idx];
              out_idx = out_idx - 1;
            end
          end else if (bus[g].mosi != p_mosi) begin
            viol++;
          end
        end
        if (bus[g].done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: dut%0d pulsed done, required no done", g);
          end else begin
            e = exp_q.pop_front();
            chk("done_dut",      g, e.dut);
            chk("rx_data",       bus[g].rx_data, e.rx);
            chk("periph_rx",     cap, e.tx);
            chk("sclk_edges",    edges, 16);
            chk("done_latency",  cyc - fall_cyc, 17 * DIV);
            chk("busy_at_done",  bus[g].busy, 0);
            chk("ss_at_done",    bus[g].ss, 1);
            chk("sclk_idle",     bus[g].sclk, e.cpol);
            chk("mosi_timing",   viol, 0);
          end
          done_cyc  = cyc;
          have_done = 1'b1;
        end
      end
      p_ss   = bus[g].ss;
      p_sclk = bus[g].sclk;
      p_mosi = bus[g].mosi;
    end
  end

  // caller is at a negedge with the target DUT idle
  task automatic launch(input int g, input logic [1:0] m, input logic [7:0] tx,
                        input logic [7:0] resp, input bit loop);
    exp_t e;
    slv_mode[g] = m;
    slv_resp[g] = resp;
    slv_loop[g] = loop;
    mode_s[g]   = m;
    tx_s[g]     = tx;
    start_s[g]  = 1'b1;
    e.dut  = 2'(g);
    e.tx   = tx;
    e.rx   = loop ? tx : resp;
    e.cpol = m[1];
    exp_q.push_back(e);
    @(negedge inclk);
    start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge inclk);
      n++;
    end
    chk("done_timeout_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge inclk);
  endtask

  task automatic wait_edges0(input int n);
    int   seen = 0;
    int   t = 0;
    logic p;
    p = bus[0].sclk;
    while (seen < n && t < 2000) begin
      @(negedge inclk);
      t++;
      if (bus[0].sclk !== p) begin
        seen++;
        p = bus[0].sclk;
      end
    end
    chk("edge_wait", seen, n);
  endtask

  task automatic wait_fall1();
    int t = 0;
    while (!bus[1].ss && t < 100) begin
      @(negedge inclk);
      t++;
    end
    while (bus[1].ss && t < 100) begin
      @(negedge inclk);
      t++;
    end
    chk("ss_fall_wait", bus[1].ss, 0);
  endtask

  initial begin
    logic [1:0] m;
    logic [7:0] tx;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; mode_s[i] = 2'b00; tx_s[i] = 8'h00;
      slv_loop[i] = 1'b0; slv_mode[i] = 2'b00; slv_resp[i] = 8'h00; back2back[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge inclk);
    chk("rst_ss",   bus[0].ss, 1);
    chk("rst_busy", bus[0].busy, 0);
    chk("rst_done", bus[0].done, 0);
    chk("rst_rx",   bus[0].rx_data, 8'h00);
    chk("rst_sclk", bus[0].sclk, 0);
    chk("rst_mosi", bus[0].mosi, 0);
    reset = 1'b0;
    @(negedge inclk);

    // mode 0 loopback
    launch(0, SPI_MODE0, 8'hA5, 8'h00, 1'b1);
    wait_done(200);
    // mode 3 against a fixed peripheral reply, sclk must park high
    launch(0, SPI_MODE3, 8'h0F, 8'h3C, 1'b0);
    wait_done(200);
    chk("mode3_idle_sclk", bus[0].sclk, 1);
    chk("mode3_idle_mosi_hold", bus[0].mosi, 1);
    // modes 1 and 2
    launch(0, SPI_MODE1, 8'h81, 8'($urandom), 1'b0);
    wait_done(200);
    launch(0, SPI_MODE2, 8'h81, 8'($urandom), 1'b0);
    wait_done(200);

    // start, new data and new mode while busy must all be ignored
    launch(0, SPI_MODE0, 8'h96, 8'h6B, 1'b0);
    wait_edges0(5);
    start_s[0] = 1'b1;
    tx_s[0]    = 8'hFF;
    mode_s[0]  = SPI_MODE3;
    @(negedge inclk);
    start_s[0] = 1'b0;
    chk("busy_after_ignored_start", bus[0].busy, 1);
    wait_done(200);
    repeat (40) @(negedge inclk);
    chk("no_restart_after_ignored", bus[0].ss, 1);

    // asynchronous abort after edge 7
    launch(0, SPI_MODE2, 8'hC3, 8'h99, 1'b0);
    wait_edges0(7);
    #1 reset = 1'b1;
    #1;
    chk("abort_ss",   bus[0].ss, 1);
    chk("abort_busy", bus[0].busy, 0);
    chk("abort_rx",   bus[0].rx_data, 8'h00);
    chk("abort_done", bus[0].done, 0);
    chk("abort_sclk", bus[0].sclk, 0);
    chk("abort_mosi", bus[0].mosi, 0);
    exp_q.delete();
    @(negedge inclk);
    reset = 1'b0;
    repeat (30) @(negedge inclk);
    chk("abort_rx_hold", bus[0].rx_data, 8'h00);
    launch(0, SPI_MODE0, 8'h5A, 8'hE7, 1'b0);
    wait_done(200);

    // randomised transfers
    for (int i = 0; i < 12; i++) begin
      m  = 2'($urandom_range(0, 3));
      tx = 8'($urandom);
      launch(0, m, tx, 8'($urandom), 1'($urandom_range(0, 1)));
      wait_done(200);
    end

    // CLK_DIV=1, start held high: back-to-back loopback transfers
    back2back[1] = 1'b1;
    slv_loop[1]  = 1'b1;
    slv_mode[1]  = SPI_MODE0;
    mode_s[1]    = SPI_MODE0;
    start_s[1]   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      tx = 8'($urandom);
      tx_s[1] = tx;
      e.dut = 2'd1; e.tx = tx; e.rx = tx; e.cpol = 1'b0;
      exp_q.push_back(e);
      wait_fall1();
    end
    start_s[1] = 1'b0;
    tx_s[1]    = 8'h00;
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
